// File: rtl/mem_arbiter_2port.sv
// Round-robin two-requester controller for the 8x4 register memory.
// Also sweeps zeros over the whole memory on a clear command.
module mem_arbiter_2port #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start,
  output logic              clr_busy,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              ack_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              mem_sel,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE, ACCESS, DONE, CLR
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } xact_t;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  state_t            state;
  logic              last_b;
  logic              gnt_b;
  logic [ADDR_W-1:0] cnt;

  xact_t xa, xb, pick;
  logic  pick_b;

  // Ties go to whoever was not served last.
  always_comb begin
    xa = '{we: we_a, addr: addr_a, wdata: wdata_a};
    xb = '{we: we_b, addr: addr_b, wdata: wdata_b};
    pick_b = 1'b0;
    unique case (1'b1)
      req_a & req_b:  pick_b = ~last_b;
      ~req_a & req_b: pick_b = 1'b1;
      default:        pick_b = 1'b0;
    endcase
    pick = pick_b ? xb : xa;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      clr_busy  <= 1'b0;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      rdata_a   <= '0;
      rdata_b   <= '0;
      mem_sel   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      last_b    <= 1'b1;
      gnt_b     <= 1'b0;
      cnt       <= '0;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      unique case (state)
        IDLE: begin
          if (clr_start) begin
            state     <= CLR;
            clr_busy  <= 1'b1;
            mem_sel   <= 1'b1;
            mem_wr    <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cnt       <= '0;
          end else if (req_a | req_b) begin
            state     <= ACCESS;
            gnt_b     <= pick_b;
            last_b    <= pick_b;
            mem_sel   <= 1'b1;
            mem_wr    <= pick.we;
            mem_addr  <= pick.addr;
            mem_wdata <= pick.wdata;
          end
        end
        ACCESS: begin
          if (!mem_wr) begin
            if (gnt_b) rdata_b <= mem_rdata;
            else       rdata_a <= mem_rdata;
          end
          state     <= DONE;
          ack_a     <= ~gnt_b;
          ack_b     <= gnt_b;
          mem_sel   <= 1'b0;
          mem_wr    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
        end
        DONE: begin
          state <= IDLE;
        end
        CLR: begin
          if (cnt == LAST) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
            mem_sel  <= 1'b0;
            mem_wr   <= 1'b0;
            mem_addr <= '0;
            cnt      <= '0;
          end else begin
            cnt      <= cnt + 1'b1;
            mem_addr <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_2port.sv
// Bench for mem_arbiter_2port: timeline model of the arbiter
// plus an 8x4 memory, with directed scenarios on top.
module tb_mem_arbiter_2port;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr_start = 1'b0;
  logic       req_a = 1'b0, we_a = 1'b0;
  logic       req_b = 1'b0, we_b = 1'b0;
  logic [2:0] addr_a = '0, addr_b = '0;
  logic [3:0] wdata_a = '0, wdata_b = '0;
  logic       clr_busy, ack_a, ack_b;
  logic [3:0] rdata_a, rdata_b;
  logic       mem_sel, mem_wr;
  logic [2:0] mem_addr;
  logic [3:0] mem_wdata, mem_rdata;

  logic [3:0] phys [DEPTH] = '{default: 4'h0};

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter_2port #(
    .ADDR_W(3), .DATA_W(4), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a),
    .wdata_a(wdata_a), .ack_a(ack_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b),
    .wdata_b(wdata_b), .ack_b(ack_b), .rdata_b(rdata_b),
    .mem_sel(mem_sel), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always_comb mem_rdata = phys[mem_addr];

  always @(posedge clk)
    if (mem_sel && mem_wr) phys[mem_addr] <= mem_wdata;

  task automatic chk(input string nm, input int act,
                     input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d @cyc %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Model: a job occupies m_busy more cycles. A transfer is
  // 2 cycles (memory access, then ack); a clear is DEPTH.
  int         m_busy = 0;
  bit         m_clr = 1'b0, m_who = 1'b0, m_last = 1'b1;
  bit         m_we = 1'b0;
  logic [2:0] m_addr = '0;
  logic [3:0] m_wd = '0, m_rda = '0, m_rdb = '0;
  logic [3:0] ref_mem [DEPTH] = '{default: 4'h0};

  always @(posedge clk) begin
    cyc++;
    started = 1'b1;
    if (m_busy > 0) begin
      if (m_clr) ref_mem[DEPTH - m_busy] = 4'h0;
      else if (m_busy == 2 && m_we) ref_mem[m_addr] = m_wd;
    end
    if (rst) begin
      m_busy = 0;
      m_clr  = 1'b0;
      m_last = 1'b1;
      m_rda  = '0;
      m_rdb  = '0;
    end else if (m_busy > 0) begin
      if (!m_clr && m_busy == 2 && !m_we) begin
        if (m_who) m_rdb = ref_mem[m_addr];
        else       m_rda = ref_mem[m_addr];
      end
      m_busy--;
    end else if (clr_start) begin
      m_clr  = 1'b1;
      m_busy = DEPTH;
    end else if (req_a || req_b) begin
      m_clr  = 1'b0;
      m_who  = (req_a && req_b) ? !m_last : req_b;
      m_last = m_who;
      m_we   = m_who ? we_b : we_a;
      m_addr = m_who ? addr_b : addr_a;
      m_wd   = m_who ? wdata_b : wdata_a;
      m_busy = 2;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      bit e_sel, e_busy, e_aa, e_ab;
      e_busy = m_busy > 0 && m_clr;
      e_sel  = m_busy > 0 && (m_clr || m_busy == 2);
      e_aa   = !m_clr && m_busy == 1 && !m_who;
      e_ab   = !m_clr && m_busy == 1 && m_who;
      chk("mem_sel", mem_sel, e_sel);
      chk("clr_busy", clr_busy, e_busy);
      chk("ack_a", ack_a, e_aa);
      chk("ack_b", ack_b, e_ab);
      chk("rdata_a", rdata_a, m_rda);
      chk("rdata_b", rdata_b, m_rdb);
      if (e_sel) begin
        chk("mem_wr", mem_wr, m_clr ? 1 : int'(m_we));
        chk("mem_addr", mem_addr,
            m_clr ? DEPTH - m_busy : int'(m_addr));
        chk("mem_wdata", mem_wdata,
            m_clr ? 0 : int'(m_wd));
      end
    end
  end

  task automatic xact(input bit b, input bit we,
                      input logic [2:0] a,
                      input logic [3:0] d,
                      output int lat, output bit wr);
    int c0;
    bit got;
    @(posedge clk); #1;
    if (b) begin
      req_b = 1; we_b = we; addr_b = a; wdata_b = d;
    end else begin
      req_a = 1; we_a = we; addr_a = a; wdata_a = d;
    end
    c0 = cyc;
    got = 0;
    wr = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (mem_sel) wr = mem_wr;
      got = b ? ack_b : ack_a;
    end
    lat = cyc - c0;
    if (!got) chk("ack_timeout", 0, 1);
    @(posedge clk); #1;
    if (b) req_b = 0;
    else   req_a = 0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    clr_start = 1;
    @(posedge clk); #1;
    clr_start = 0;
  endtask

  int lat, nb, c0, n;
  bit wr, seen, bat, got;
  int ord [$];
  int when [$];

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_sel", mem_sel, 0);
    chk("rst_rdata_a", rdata_a, 0);

    // 1: A writes, B reads back
    xact(0, 1, 3, 4'hA, lat, wr);
    chk("t1_lat", lat, 2);
    xact(1, 0, 3, 4'h0, lat, wr);
    chk("t1_rdata_b", rdata_b, 4'hA);
    chk("t1_rdata_a", rdata_a, 0);

    // 2: both held -> a,b,a,b every 3 cycles
    @(posedge clk); #1;
    req_a = 1; we_a = 0; addr_a = 3;
    req_b = 1; we_b = 0; addr_b = 5;
    c0 = cyc;
    ord.delete();
    when.delete();
    for (int i = 0; i < 20 && ord.size() < 4; i++) begin
      @(negedge clk);
      if (ack_a) begin ord.push_back(0); when.push_back(cyc); end
      if (ack_b) begin ord.push_back(1); when.push_back(cyc); end
    end
    @(posedge clk); #1;
    req_a = 0; req_b = 0;
    chk("t2_acks", ord.size(), 4);
    if (ord.size() == 4) begin
      chk("t2_first_lat", when[0] - c0, 2);
      for (int k = 0; k < 4; k++)
        chk("t2_order", ord[k], k % 2);
      for (int k = 1; k < 4; k++)
        chk("t2_gap", when[k] - when[k-1], 3);
    end
    chk("t2_rdata_a", rdata_a, 4'hA);
    chk("t2_rdata_b", rdata_b, 0);

    // 3: fill with 5, clear, read back zeros
    for (int i = 0; i < DEPTH; i++)
      xact(0, 1, 3'(i), 4'h5, lat, wr);
    xact(1, 0, 7, 4'h0, lat, wr);
    chk("t3_pre", rdata_b, 4'h5);
    pulse_clr();
    nb = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (clr_busy) begin
        chk("t3_addr", mem_addr, nb);
        chk("t3_wr", mem_wr, 1);
        chk("t3_wdata", mem_wdata, 0);
        nb++;
      end
    end
    chk("t3_busy_cycles", nb, 8);
    for (int i = 0; i < DEPTH; i++) begin
      xact(1, 0, 3'(i), 4'h0, lat, wr);
      chk("t3_read0", rdata_b, 0);
    end

    // 4: clear and read requested together
    xact(0, 1, 2, 4'h7, lat, wr);
    xact(0, 0, 2, 4'h0, lat, wr);
    chk("t4_pre", rdata_a, 4'h7);
    @(posedge clk); #1;
    clr_start = 1;
    req_a = 1; we_a = 0; addr_a = 2;
    c0 = cyc;
    @(posedge clk); #1;
    clr_start = 0;
    seen = 0; bat = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (clr_busy) seen = 1;
      if (ack_a) begin got = 1; bat = clr_busy; end
    end
    lat = cyc - c0;
    @(posedge clk); #1;
    req_a = 0;
    chk("t4_acked", got, 1);
    chk("t4_clr_seen", seen, 1);
    chk("t4_busy_at_ack", bat, 0);
    chk("t4_lat", lat, 11);
    chk("t4_rdata_a", rdata_a, 0);

    // 5: reset in the middle of a clear
    for (int i = 0; i < DEPTH; i++)
      xact(0, 1, 3'(i), 4'h5, lat, wr);
    pulse_clr();
    got = 0; n = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (ack_a || ack_b) n++;
      got = clr_busy && mem_addr == 4;
    end
    chk("t5_reached4", got, 1);
    rst = 1;
    @(negedge clk);
    chk("t5_busy", clr_busy, 0);
    chk("t5_sel", mem_sel, 0);
    rst = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack_a || ack_b) n++;
    end
    chk("t5_no_ack", n, 0);
    for (int i = 0; i < DEPTH; i++)
      chk("t5_mem", phys[i], i > 4 ? 5 : 0);

    // 6: write, read, write on A
    xact(0, 1, 6, 4'h9, lat, wr);
    chk("t6_wr1", wr, 1);
    xact(0, 0, 6, 4'h0, lat, wr);
    chk("t6_wr0", wr, 0);
    chk("t6_rdata", rdata_a, 4'h9);
    xact(0, 1, 6, 4'h3, lat, wr);
    chk("t6_hold", rdata_a, 4'h9);
    xact(1, 0, 6, 4'h0, lat, wr);
    chk("t6_rdata_b", rdata_b, 4'h3);

    for (int i = 0; i < DEPTH; i++)
      chk("final_mem", phys[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
